// File: rtl/somasub_pipe.sv
// somasub_pipe: registered WIDTH-bit add/subtract unit with an accumulator and valid/ready handshakes.
// Optional signed saturation is built in when the macro SOMASUB_SAT_EN is defined.
module somasub_pipe #(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             sign,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] acc
);
    localparam int MSB = WIDTH - 1;

    logic             accept;
    logic             is_sub;
    logic             is_acc;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             carry_next;
    logic             ovf_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] r_reg;
    logic             zero_reg;
    logic             sign_reg;
    logic             carry_reg;
    logic             overflow_reg;
    logic [WIDTH-1:0] acc_reg;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_sub   = op[0];
    assign is_acc   = op[1];

    // A same-cycle clear makes the accumulator op start from ACC_INIT.
    assign x = is_acc ? (acc_clr ? ACC_INIT : acc_reg) : a;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_eff[gi] = b[gi] ^ is_sub;
        end
    endgenerate

    assign sum        = {1'b0, x} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign raw        = sum[MSB:0];
    assign carry_next = sum[WIDTH] ^ is_sub;
    // Operand signs must match for add, differ for sub, before a sign flip means overflow.
    assign ovf_next   = ((x[MSB] ^ b[MSB]) == is_sub) && (raw[MSB] != x[MSB]);

`ifdef SOMASUB_SAT_EN
    assign res = ovf_next ? {x[MSB], {MSB{~x[MSB]}}} : raw;
`else
    assign res = raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            r_reg         <= '0;
            zero_reg      <= 1'b0;
            sign_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            acc_reg       <= ACC_INIT;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                r_reg         <= res;
                zero_reg      <= (res == '0);
                sign_reg      <= res[MSB];
                carry_reg     <= carry_next;
                overflow_reg  <= ovf_next;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

            if (accept && is_acc) begin
                acc_reg <= res;
            end else if (acc_clr) begin
                acc_reg <= ACC_INIT;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign r         = r_reg;
    assign zero      = zero_reg;
    assign sign      = sign_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;
    assign acc       = acc_reg;
endmodule

// File: tb/tb_somasub_pipe.sv
// Testbench for somasub_pipe: directed vector table, handshake/reset sequences, then random traffic
// against an arithmetic reference model. Honours SOMASUB_SAT_EN when defined.
module tb_somasub_pipe;
    localparam int            W    = 4;
    localparam logic [W-1:0]  INIT = '0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         zero;
    logic         sign;
    logic         carry;
    logic         overflow;
    logic [W-1:0] acc;

    always #5 clk = ~clk;

    somasub_pipe #(.WIDTH(W), .ACC_INIT(INIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .zero(zero), .sign(sign), .carry(carry), .overflow(overflow), .acc(acc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         clr;
        logic [W-1:0] r;
        logic         z;
        logic         s;
        logic         c;
        logic         o;
        logic [W-1:0] acc;
    } vec_t;

    vec_t vecs[$];

    logic         m_valid;
    logic [W-1:0] m_r;
    logic         m_z, m_s, m_c, m_o;
    logic [W-1:0] m_acc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic with unsigned carry/borrow and signed range test.
    function automatic void model_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic clr, input logic [W-1:0] acc_in,
                                     output logic [W-1:0] rv, output logic zv, output logic sv,
                                     output logic cv, output logic ov);
        int ux, ub, sx, sb, ss, us;
        ux = o[1] ? int'(clr ? INIT : acc_in) : int'(av);
        ub = int'(bv);
        sx = (ux >= 2**(W-1)) ? ux - 2**W : ux;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        if (!o[0]) begin
            us = ux + ub;
            cv = (us >= 2**W);
            ss = sx + sb;
        end else begin
            us = ux - ub;
            cv = (ux < ub);
            ss = sx - sb;
        end
        ov = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
        rv = us[W-1:0];
`ifdef SOMASUB_SAT_EN
        if (ov) rv = (sx >= 0) ? W'(2**(W-1) - 1) : W'(2**(W-1));
`endif
        zv = (rv == '0);
        sv = rv[W-1];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " out_valid"}, int'(out_valid), int'(m_valid));
        chk({tag, " r"},         int'(r),         int'(m_r));
        chk({tag, " zero"},      int'(zero),      int'(m_z));
        chk({tag, " sign"},      int'(sign),      int'(m_s));
        chk({tag, " carry"},     int'(carry),     int'(m_c));
        chk({tag, " overflow"},  int'(overflow),  int'(m_o));
        chk({tag, " acc"},       int'(acc),       int'(m_acc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc_ok;
        logic [W-1:0] rv;
        logic         zv, sv, cv, ov;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
        op = 2'b00; a = '0; b = '0;

        //               op     a        b        clr   r        z     s     c     o     acc
`ifdef SOMASUB_SAT_EN
        vecs.push_back('{2'b00, 4'b0111, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000});
`else
        vecs.push_back('{2'b00, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000});
`endif
        vecs.push_back('{2'b01, 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000});
        vecs.push_back('{2'b01, 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{2'b10, 4'b0000, 4'b0011, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011});
        vecs.push_back('{2'b10, 4'b1010, 4'b0011, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110});
`ifdef SOMASUB_SAT_EN
        vecs.push_back('{2'b10, 4'b0000, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0111});
        vecs.push_back('{2'b11, 4'b0000, 4'b1001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0111});
`else
        vecs.push_back('{2'b10, 4'b0000, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001});
        vecs.push_back('{2'b11, 4'b0000, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000});
`endif
        vecs.push_back('{2'b10, 4'b0000, 4'b0101, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101});
        vecs.push_back('{2'b10, 4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010});
        vecs.push_back('{2'b00, 4'b0010, 4'b0011, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
`ifdef SOMASUB_SAT_EN
        vecs.push_back('{2'b01, 4'b1000, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000});
`else
        vecs.push_back('{2'b01, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000});
`endif
        vecs.push_back('{2'b00, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000});
        vecs.push_back('{2'b11, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready",  int'(in_ready),  1);
        chk("reset r",         int'(r),         0);
        chk("reset zero",      int'(zero),      0);
        chk("reset sign",      int'(sign),      0);
        chk("reset carry",     int'(carry),     0);
        chk("reset overflow",  int'(overflow),  0);
        chk("reset acc",       int'(acc),       int'(INIT));
        rst = 1'b0;

        foreach (vecs[i]) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; acc_clr = vecs[i].clr;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; acc_clr = 1'b0;
            $display("vec %0d op=%b a=%b b=%b clr=%b -> r=%b z=%b s=%b c=%b o=%b acc=%b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].clr, r, zero, sign, carry, overflow, acc);
            chk($sformatf("vec%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("vec%0d r", i),         int'(r),         int'(vecs[i].r));
            chk($sformatf("vec%0d zero", i),      int'(zero),      int'(vecs[i].z));
            chk($sformatf("vec%0d sign", i),      int'(sign),      int'(vecs[i].s));
            chk($sformatf("vec%0d carry", i),     int'(carry),     int'(vecs[i].c));
            chk($sformatf("vec%0d overflow", i),  int'(overflow),  int'(vecs[i].o));
            chk($sformatf("vec%0d acc", i),       int'(acc),       int'(vecs[i].acc));
        end

        // Stall: result held, nothing accepted, then release with no bubble.
        op = 2'b00; a = 4'd2; b = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        $display("hold: first result r=%b out_valid=%b", r, out_valid);
        chk("hold first r", int'(r), 5);
        a = 4'd1; b = 4'd1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d in_ready", k), int'(in_ready), 0);
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", k), int'(out_valid), 1);
            chk($sformatf("hold%0d r", k),         int'(r),         5);
            chk($sformatf("hold%0d flags", k),     int'({zero, sign, carry, overflow}), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", int'(in_ready), 1);
        @(negedge clk);
        $display("release: r=%b out_valid=%b", r, out_valid);
        chk("release out_valid", int'(out_valid), 1);
        chk("release r",         int'(r),         2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain out_valid", int'(out_valid), 0);
        chk("drain r kept",    int'(r),         2);

        // Reset mid-stream overrides a transaction accepted in the same cycle.
        op = 2'b10; b = 4'd4; in_valid = 1'b1;
        @(negedge clk);
        chk("pre-rst out_valid", int'(out_valid), 1);
        chk("pre-rst acc",       int'(acc),       3);
        chk("pre-rst carry",     int'(carry),     1);
        b = 4'd1; rst = 1'b1;
        @(negedge clk);
        $display("midrst: out_valid=%b acc=%b r=%b", out_valid, acc, r);
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst acc",       int'(acc),       int'(INIT));
        chk("midrst r",         int'(r),         0);
        rst = 1'b0; in_valid = 1'b0;

        m_valid = 1'b0; m_r = '0; m_z = 1'b0; m_s = 1'b0; m_c = 1'b0; m_o = 1'b0; m_acc = INIT;
        for (int n = 0; n < 400; n++) begin
            check_model($sformatf("rnd%0d", n));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom_range(0, 3));
            a         = W'($urandom);
            b         = W'($urandom);
            acc_clr   = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            #1;
            chk($sformatf("rnd%0d in_ready", n), int'(in_ready), int'(!m_valid || out_ready));
            acc_ok = in_valid && (!m_valid || out_ready);
            if (rst) begin
                m_valid = 1'b0; m_r = '0; m_z = 1'b0; m_s = 1'b0; m_c = 1'b0; m_o = 1'b0; m_acc = INIT;
            end else begin
                if (acc_ok) begin
                    model_op(op, a, b, acc_clr, m_acc, rv, zv, sv, cv, ov);
                    $display("rnd %0d op=%b a=%h b=%h clr=%b -> r=%h z=%b s=%b c=%b o=%b",
                             n, op, a, b, acc_clr, rv, zv, sv, cv, ov);
                    m_valid = 1'b1; m_r = rv; m_z = zv; m_s = sv; m_c = cv; m_o = ov;
                    if (op[1]) m_acc = rv;
                    else if (acc_clr) m_acc = INIT;
                end else begin
                    if (out_ready) m_valid = 1'b0;
                    if (acc_clr) m_acc = INIT;
                end
            end
            @(negedge clk);
        end
        check_model("final");
        rst = 1'b0; in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/somasub_pipe.md
Name: somasub_pipe

Overview:
Parametrised registered add/subtract unit with an internal accumulator. It generalises the team's combinational 4-bit SOMASUB to WIDTH bits and adds a valid/ready handshake on input and output. Flags are full and correct: zero, sign, unsigned carry/borrow and signed overflow. It sits between operand sources (register file or counters) and any consumer that may stall.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)
ACC_INIT, 0, accumulator value after reset or acc_clr (WIDTH bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand transaction present
in_ready  output  1  unit can accept a transaction this cycle
a  input  WIDTH  operand A (ignored by accumulator ops)
b  input  WIDTH  operand B
op  input  2  00 R=A+B; 01 R=A-B; 10 ACC=ACC+B; 11 ACC=ACC-B
acc_clr  input  1  synchronous accumulator clear to ACC_INIT
out_valid  output  1  registered result available
out_ready  input  1  consumer accepts result
r  output  WIDTH  result
zero  output  1  r == 0
sign  output  1  r[WIDTH-1]
carry  output  1  add: unsigned carry-out; sub: borrow (1 when minuend < B unsigned)
overflow  output  1  signed two's-complement overflow
acc  output  WIDTH  current accumulator value

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. On rst: out_valid=0, r=0, zero=0, sign=0, carry=0, overflow=0, acc=ACC_INIT. rst overrides every other input, including a transaction accepted in the same cycle.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept condition: in_valid && in_ready. Latency is 1 cycle: results and flags appear registered on the next edge with out_valid=1.
- Output hold: while out_valid && !out_ready, r and all flags stay stable and nothing is accepted.
- If out_ready && !accept, out_valid goes to 0 next cycle. r and flags keep their last values.
- Back-to-back: out_valid=1, out_ready=1 and in_valid=1 gives a new result on the next edge with no bubble. Throughput is 1 per cycle.
- Arithmetic uses a WIDTH+1-bit internal sum; r is the low WIDTH bits.
  - Add: carry = sum[WIDTH].
  - Sub: computed as X + ~B + 1; carry = !sum[WIDTH] (borrow).
  - Add overflow = (X[msb]==B[msb]) && (r[msb]!=X[msb]).
  - Sub overflow = (X[msb]!=B[msb]) && (r[msb]!=X[msb]).
  - X is a for ops 00/01 and the current acc for ops 10/11.
- Accumulator ops (10/11): acc <= r on the same edge the result registers. The output reports the new acc value.
- acc_clr with no accept: acc <= ACC_INIT.
- acc_clr together with an accepted accumulator op: X is taken as ACC_INIT, so clear happens first, then the op. acc and r hold ACC_INIT±B.
- acc_clr together with op 00/01: both take effect independently.
- Wrap-around: without the optional feature, results wrap modulo 2^WIDTH and flags report the event.

Optional Feature:
SOMASUB_SAT_EN. When defined, signed saturation is applied.
- On overflow, r (and acc for ops 10/11) is clamped: 0 then all ones (most-positive) if X was non-negative, 1 then all zeros (most-negative) otherwise.
- overflow still reports 1. zero and sign are computed from the clamped value. carry is unchanged.
When undefined, results wrap and no clamp logic is present.

Test Plan:
- rst=1 for 2 cycles, then WIDTH=4: accept a=0111, b=0001, op=00 -> next cycle out_valid=1, r=1000, overflow=1, sign=1, carry=0, zero=0.
- a=0011, b=0101, op=01 -> r=1110, carry=1, overflow=0, sign=1. Then a=0101, b=0101, op=01 -> r=0000, zero=1, carry=0.
- Hold out_ready=0 for 3 cycles after a result -> in_ready=0, r and flags constant. Raise out_ready with in_valid=1 -> new result next cycle, no bubble.
- acc_clr, then op=10 with b=0011 three times -> acc 0011, 0110, 1001 (third has overflow=1). Then op=11 with b=1001 -> acc=0000, zero=1.
- acc_clr with op=10, b=0010 in the same cycle while acc=0101 -> acc=0010, r=0010.
- With SOMASUB_SAT_EN: 0111+0001 -> r=0111, overflow=1. 1000-0001 -> r=1000, overflow=1. Mid-stream rst with out_valid=1 -> out_valid=0 and acc=ACC_INIT next cycle.
